time_fifo_tx: RTL and testbench
===============================

// Module: time_fifo_tx
//
// PURPOSE
//   Synthesizable profiling transmitter. It counts the cycles a monitored unit
//   spends in each state: idle, calc and done. On a dump request it snapshots
//   the counters and streams them out over a valid/ready interface, so a host or
//   logger can print the breakdown. One instance sits beside each monitored
//   FIFO/layer unit and is the hardware source of the profiling data.
//
// PARAMETERS
//   CNT_WIDTH      32  width of each cycle counter and of out_data
//   CLEAR_ON_DUMP  0   1: counters restart from zero when a dump is accepted
//   UNIT_ID        0   8-bit tag, driven on out_id for every word
//
// PORTS
//   clk        in   1          clock
//   rst        in   1          synchronous active-high reset
//   state      in   2          monitored state: 0 idle, 1 calc, 2 done, 3 other
//   dump       in   1          single-cycle request to snapshot and transmit
//   out_data   out  CNT_WIDTH  counter value of the current word
//   out_sel    out  2          word index: 0 idle, 1 calc, 2 done, 3 total
//   out_id     out  8          UNIT_ID, constant
//   out_valid  out  1          word available
//   out_ready  in   1          consumer accepts the word when valid&ready
//   busy       out  1          a transmission is in progress
//
// BEHAVIOUR
// - Reset (rst=1 at a clk edge):
//   - Counters, snapshot, out_data, out_sel, out_valid and busy all go to 0.
//   - FSM goes to S_IDLE.
//   - Reset overrides everything, including a transmission in progress. out_valid
//     is low in the cycle after reset, and the interrupted frame is abandoned.
// - Counting (every non-reset cycle):
//   - Increment: state 0 -> cnt_idle, 1 -> cnt_calc, 2 -> cnt_done.
//   - cnt_total increments every cycle, including cycles with state 3.
//   - All counters saturate at 2^CNT_WIDTH-1. They never wrap.
//   - Counting continues while a transmission is in progress.
// - FSM, S_IDLE -> S_SEND:
//   - Taken when dump=1. A dump in S_SEND is ignored, not queued.
//   - On that edge the snapshot captures the counter register values before the
//     current cycle's increment.
//   - If CLEAR_ON_DUMP=1, on that same edge the counters load the current
//     cycle's increment only. For example cnt_total becomes 1, and the active
//     state's counter becomes 1 while the others become 0.
//   - Latency: dump sampled at edge N -> out_valid=1, out_sel=0 after edge N.
// - FSM, S_SEND:
//   - out_valid=1 and busy=1.
//   - out_data = snapshot[out_sel], held stable until the handshake.
//   - On valid&ready at an edge, out_sel advances by 1.
//   - After word 3 is accepted, the FSM returns to S_IDLE: out_valid=0 and
//     busy=0 after that edge, and out_sel returns to 0.
//   - out_ready held high gives 4 consecutive words, one per cycle.
//   - out_ready low stalls indefinitely and emits no bubbles.
//   - out_valid never drops without a handshake, except on reset.
// - Back-to-back frames: a dump in the same cycle as the final handshake is
//   ignored. The earliest accepted dump is in the cycle after busy falls.
// - Snapshot words are a consistent set. idle+calc+done+(state-3 cycles) equals
//   total, unless a counter has saturated.
// - out_id equals UNIT_ID at all times, including during reset.
//
// TESTING
// 1. Reset, state=0 for 5 cycles, 1 for 3 cycles, 2 for 2 cycles, then dump,
//    out_ready=1 -> words (sel,data) = (0,5) (1,3) (2,2) (3,10) on 4
//    consecutive cycles, out_valid first high the cycle after dump.
// 2. Same as 1 with out_ready toggling 1,0,0,1,... -> identical 4 words, each
//    held stable while stalled, with no duplicates or drops.
// 3. dump pulsed again while busy -> ignored, exactly one frame.
//    CLEAR_ON_DUMP=0 -> a second dump later reports cumulative counts.
//    CLEAR_ON_DUMP=1 -> it reports counts since the first dump plus 1.
// 4. CNT_WIDTH=4, state=1 for 20 cycles, dump -> calc=15, total=15
//    (saturated, not wrapped).
// 5. rst asserted while out_sel=2 and stalled -> out_valid=0 and busy=0 next
//    cycle. A new dump after 3 idle cycles -> idle=3, total=3.
// 6. state=3 for 4 cycles, dump -> idle=calc=done=0, total=4.

Source files
------------

// File: rtl/time_fifo_tx_if.sv
// Output stream of the profiling transmitter: one counter word per handshake,
// tagged with its word index and the unit id.
interface time_fifo_tx_if #(
  parameter int CNT_WIDTH = 32
);
  logic [CNT_WIDTH-1:0] out_data;
  logic [1:0]           out_sel;
  logic [7:0]           out_id;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_data, out_sel, out_id, out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data, out_sel, out_id, out_valid,
    output out_ready
  );
endinterface

// File: rtl/time_fifo_tx.sv
// Profiling transmitter: counts cycles per monitored state and, on dump,
// snapshots the counters and streams idle/calc/done/total words.
module time_fifo_tx #(
  parameter int       CNT_WIDTH     = 32,
  parameter bit       CLEAR_ON_DUMP = 1'b0,
  parameter bit [7:0] UNIT_ID       = 8'd0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           state,
  input  logic                 dump,
  output logic                 busy,
  time_fifo_tx_if.master       tx
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic {
    S_IDLE,
    S_SEND
  } fsm_e;

  fsm_e                 fsm_q, fsm_d;
  logic [CNT_WIDTH-1:0] cnt_q    [4];
  logic [CNT_WIDTH-1:0] cnt_next [4];
  logic [CNT_WIDTH-1:0] snap_q   [4];
  logic [1:0]           sel_q;
  logic [3:0]           inc;
  logic                 take;
  logic                 accept;
  logic                 send;

  // Index 3 is the total, which advances every cycle regardless of state.
  always_comb begin
    inc[0] = (state == 2'd0);
    inc[1] = (state == 2'd1);
    inc[2] = (state == 2'd2);
    inc[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i]
                                          : cnt_q[i] + CNT_WIDTH'(inc[i]);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    fsm_d  = fsm_q;
    take   = 1'b0;
    accept = 1'b0;
    send   = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        if (dump) begin
          take  = 1'b1;
          fsm_d = S_SEND;
        end
      end
      S_SEND: begin
        send = 1'b1;
        if (tx.out_ready) begin
          accept = 1'b1;
          if (sel_q == 2'd3) fsm_d = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) fsm_q <= S_IDLE;
    else     fsm_q <= fsm_d;
  end

  // Snapshot takes the pre-increment counter values, so the four words are a
  // consistent set even when the counters are cleared on the same edge.
  // NOTE: the snapshot is four flops, not a RAM, so it can and does take the
  // reset; that also pins out_data to zero while idle after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (take && CLEAR_ON_DUMP) cnt_q[i] <= CNT_WIDTH'(inc[i]);
        else                       cnt_q[i] <= cnt_next[i];
        if (take) snap_q[i] <= cnt_q[i];
      end
    end
  end

  // Word index wraps 3 -> 0 on the final handshake, ready for the next frame.
  always_ff @(posedge clk) begin
    if (rst)         sel_q <= 2'd0;
    else if (accept) sel_q <= sel_q + 2'd1;
  end

  assign tx.out_data  = snap_q[sel_q];
  assign tx.out_sel   = sel_q;
  assign tx.out_id    = UNIT_ID;
  assign tx.out_valid = send;
  assign busy         = send;

endmodule

// File: tb/tb_time_fifo_tx.sv
// Directed bench: three instances (plain, clear-on-dump, 4-bit counters)
// share stimulus and are checked against hand-computed frames.
module tb_time_fifo_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;
  logic       dump;
  logic       ready;
  logic       busy_a, busy_b, busy_c;

  int n_vec  = 0;
  int n_miss = 0;

  time_fifo_tx_if #(.CNT_WIDTH(32)) bus_a ();
  time_fifo_tx_if #(.CNT_WIDTH(32)) bus_b ();
  time_fifo_tx_if #(.CNT_WIDTH(4))  bus_c ();

  assign bus_a.out_ready = ready;
  assign bus_b.out_ready = ready;
  assign bus_c.out_ready = ready;

  time_fifo_tx #(.CNT_WIDTH(32), .CLEAR_ON_DUMP(1'b0), .UNIT_ID(8'h5A)) dut_a (
    .clk(clk), .rst(rst), .state(state), .dump(dump), .busy(busy_a), .tx(bus_a)
  );
  time_fifo_tx #(.CNT_WIDTH(32), .CLEAR_ON_DUMP(1'b1), .UNIT_ID(8'hA5)) dut_b (
    .clk(clk), .rst(rst), .state(state), .dump(dump), .busy(busy_b), .tx(bus_b)
  );
  time_fifo_tx #(.CNT_WIDTH(4), .CLEAR_ON_DUMP(1'b0), .UNIT_ID(8'h0C)) dut_c (
    .clk(clk), .rst(rst), .state(state), .dump(dump), .busy(busy_c), .tx(bus_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][31:0] words(input int i, input int c, input int d, input int t);
    return {32'(t), 32'(d), 32'(c), 32'(i)};
  endfunction

  task automatic check_idle(input string tag);
    check({tag, ".a.valid"}, 32'(bus_a.out_valid), 32'd0);
    check({tag, ".b.valid"}, 32'(bus_b.out_valid), 32'd0);
    check({tag, ".c.valid"}, 32'(bus_c.out_valid), 32'd0);
    check({tag, ".a.busy"},  32'(busy_a), 32'd0);
    check({tag, ".b.busy"},  32'(busy_b), 32'd0);
    check({tag, ".c.busy"},  32'(busy_c), 32'd0);
    check({tag, ".a.sel"},   32'(bus_a.out_sel), 32'd0);
    check({tag, ".c.sel"},   32'(bus_c.out_sel), 32'd0);
  endtask

  // Entered #1 after the dump edge. Ready is always-high or 1,0,0,1,0,0...;
  // hold_dump keeps dump asserted for the whole frame, final handshake included.
  task automatic run_frame(input string tag, input logic [3:0][31:0] ea,
                           input logic [3:0][31:0] eb, input logic [3:0][31:0] ec,
                           input bit stall, input bit hold_dump);
    int w   = 0;
    int cyc = 0;
    dump = hold_dump;
    while (w < 4 && cyc < 64) begin
      ready = stall ? (cyc % 3 == 0) : 1'b1;
      check($sformatf("%s.w%0d.a.valid", tag, w), 32'(bus_a.out_valid), 32'd1);
      check($sformatf("%s.w%0d.a.busy",  tag, w), 32'(busy_a), 32'd1);
      check($sformatf("%s.w%0d.a.sel",   tag, w), 32'(bus_a.out_sel), 32'(w));
      check($sformatf("%s.w%0d.a.data",  tag, w), bus_a.out_data, ea[w]);
      check($sformatf("%s.w%0d.b.valid", tag, w), 32'(bus_b.out_valid), 32'd1);
      check($sformatf("%s.w%0d.b.sel",   tag, w), 32'(bus_b.out_sel), 32'(w));
      check($sformatf("%s.w%0d.b.data",  tag, w), bus_b.out_data, eb[w]);
      check($sformatf("%s.w%0d.c.valid", tag, w), 32'(bus_c.out_valid), 32'd1);
      check($sformatf("%s.w%0d.c.sel",   tag, w), 32'(bus_c.out_sel), 32'(w));
      check($sformatf("%s.w%0d.c.data",  tag, w), 32'(bus_c.out_data), ec[w]);
      if (ready) w++;
      step();
      cyc++;
    end
    check({tag, ".words_accepted"}, 32'(w), 32'd4);
    dump  = 1'b0;
    ready = 1'b0;
    check_idle({tag, ".end"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    state = 2'd0;
    dump  = 1'b0;
    ready = 1'b0;
    step();
    check_idle("reset");
    check("reset.a.data", bus_a.out_data, 32'd0);
    check("reset.c.data", 32'(bus_c.out_data), 32'd0);
    check("reset.a.id", 32'(bus_a.out_id), 32'h5A);
    check("reset.b.id", 32'(bus_b.out_id), 32'hA5);
    check("reset.c.id", 32'(bus_c.out_id), 32'h0C);
    rst = 1'b0;

    // Test 1: 5 idle, 3 calc, 2 done, dump while state=3, ready held high.
    state = 2'd0; repeat (5) step();
    state = 2'd1; repeat (3) step();
    state = 2'd2; repeat (2) step();
    state = 2'd3;
    dump  = 1'b1;
    check("t1.pre_dump.a.valid", 32'(bus_a.out_valid), 32'd0);
    step();
    dump = 1'b0;
    run_frame("t1", words(5, 3, 2, 10), words(5, 3, 2, 10), words(5, 3, 2, 10), 1'b0, 1'b0);
    // a/c now (5,3,2,15); b cleared to total=1 on dump, now (0,0,0,5).

    // Test 2/3: stalled ready, dump held high throughout the frame.
    state = 2'd0; repeat (2) step();
    state = 2'd1; step();
    state = 2'd3;
    dump  = 1'b1;
    step();
    run_frame("t2", words(7, 4, 2, 18), words(2, 1, 0, 8), words(7, 4, 2, 15), 1'b1, 1'b1);
    step();
    check_idle("t2.no_queued_frame");
    // a (7,4,2,30), b (0,0,0,12), c (7,4,2,15 saturated).
    state = 2'd2; repeat (3) step();
    state = 2'd3;
    dump  = 1'b1;
    step();
    dump = 1'b0;
    run_frame("t3", words(7, 4, 5, 33), words(0, 0, 3, 15), words(7, 4, 5, 15), 1'b0, 1'b0);

    // Test 4: saturation of the 4-bit instance.
    rst = 1'b1; step(); rst = 1'b0;
    state = 2'd1; repeat (20) step();
    dump = 1'b1;
    step();
    dump = 1'b0;
    run_frame("t4", words(0, 20, 0, 20), words(0, 20, 0, 20), words(0, 15, 0, 15), 1'b0, 1'b0);

    // Test 5: reset while stalled on word 2.
    dump = 1'b1;
    step();
    dump  = 1'b0;
    ready = 1'b1;
    step();
    step();
    ready = 1'b0;
    check("t5.stall.a.sel", 32'(bus_a.out_sel), 32'd2);
    check("t5.stall.a.valid", 32'(bus_a.out_valid), 32'd1);
    step();
    check("t5.stall2.a.sel", 32'(bus_a.out_sel), 32'd2);
    check("t5.stall2.a.data", bus_a.out_data, 32'd0);
    check("t5.stall2.b.valid", 32'(bus_b.out_valid), 32'd1);
    rst = 1'b1;
    step();
    check_idle("t5.after_rst");
    check("t5.after_rst.a.data", bus_a.out_data, 32'd0);
    check("t5.after_rst.a.id", 32'(bus_a.out_id), 32'h5A);
    rst   = 1'b0;
    state = 2'd0;
    repeat (3) step();
    dump = 1'b1;
    step();
    dump = 1'b0;
    run_frame("t5", words(3, 0, 0, 3), words(3, 0, 0, 3), words(3, 0, 0, 3), 1'b0, 1'b0);

    // Test 6: only state-3 cycles reach the total.
    rst = 1'b1; step(); rst = 1'b0;
    state = 2'd3; repeat (4) step();
    dump = 1'b1;
    step();
    dump = 1'b0;
    run_frame("t6", words(0, 0, 0, 4), words(0, 0, 0, 4), words(0, 0, 0, 4), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
